alu_exec_unit: RTL and testbench

- Execute-stage ALU that consumes the 3-bit ALU control code produced by the ALU decoder, together with the two operands.
- Returns a registered result and zero flag over a valid/ready handshake.
- Add/sub/and/or/slt complete in one cycle.
- The three spare control codes carry shifts (sll/srl/sra), which run on an iterative 1-bit-per-cycle shifter.
- Prepares the datapath for multi-cycle execution without a barrel shifter.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/iter_shifter.sv | 65 ++++++
 rtl/alu_exec_unit.sv | 129 ++++++++++++
 tb/tb_alu_exec_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes and execute-unit state encoding.
// The ALU decoder and the execute unit both import these constants.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SRA = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } alu_state_e;

    function automatic logic is_shift_op(input logic [2:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

endpackage

// File: rtl/iter_shifter.sv
// Iterative one-bit-per-cycle shifter: working register, step counter and fill logic.
// done is high during the cycle whose step is the final one; step_result is that step's value.
module iter_shifter
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [2:0]         mode,
    input  logic [XLEN-1:0]    data,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [XLEN-1:0]    step_result,
    output logic               done
);

    localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

    logic [XLEN-1:0]    work_r;
    logic [SHAMT_W-1:0] cnt_r;
    logic [2:0]         mode_r;
    logic               busy_r;
    logic [XLEN-1:0]    step_s;

    // One-bit step of the working register in the captured direction
    always_comb begin
        step_s = work_r;
        case (mode_r)
            ALU_SLL: step_s = {work_r[XLEN-2:0], 1'b0};
            ALU_SRL: step_s = {1'b0, work_r[XLEN-1:1]};
            ALU_SRA: step_s = {work_r[XLEN-1], work_r[XLEN-1:1]};
            default: step_s = work_r;
        endcase
    end

    // Working register and countdown; the step taken while the count is one is the last
    always_ff @(posedge clk) begin
        if (rst) begin
            work_r <= {XLEN{1'b0}};
            cnt_r  <= {SHAMT_W{1'b0}};
            mode_r <= ALU_ADD;
            busy_r <= 1'b0;
        end else if (load) begin
            work_r <= data;
            cnt_r  <= shamt;
            mode_r <= mode;
            busy_r <= 1'b1;
        end else if (busy_r) begin
            work_r <= step_s;
            cnt_r  <= cnt_r - CNT_ONE;
            busy_r <= (cnt_r != CNT_ONE);
        end else begin
            work_r <= work_r;
            cnt_r  <= cnt_r;
            mode_r <= mode_r;
            busy_r <= busy_r;
        end
    end

    assign step_result = step_s;
    assign done        = busy_r && (cnt_r == CNT_ONE);

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake: single-cycle arithmetic/logic ops
// and multi-cycle shifts through the iterative shifter.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_alu_ctrl,
    input  logic [XLEN-1:0] i_src_a,
    input  logic [XLEN-1:0] i_src_b,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero,
    output logic            o_busy
);

    alu_state_e         state_r;
    alu_state_e         state_next_s;
    logic               ready_s;
    logic               accept_s;
    logic               load_s;
    logic               valid_next_s;
    logic               busy_next_s;
    logic [XLEN-1:0]    result_next_s;
    logic [XLEN-1:0]    alu_s;
    logic [XLEN-1:0]    shift_step_s;
    logic               shift_done_s;
    logic [SHAMT_W-1:0] shamt_s;

    assign shamt_s  = i_src_b[SHAMT_W-1:0];
    assign ready_s  = (state_r == IDLE) || ((state_r == DONE) && i_ready);
    assign accept_s = i_valid && ready_s;
    assign o_ready  = ready_s;

    iter_shifter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk         (i_clk),
        .rst         (i_rst),
        .load        (load_s),
        .mode        (i_alu_ctrl),
        .data        (i_src_a),
        .shamt       (shamt_s),
        .step_result (shift_step_s),
        .done        (shift_done_s)
    );

    // Single-cycle results; shift codes fall through to operand A (zero shift amount)
    always_comb begin
        alu_s = i_src_a;
        case (i_alu_ctrl)
            ALU_ADD: alu_s = i_src_a + i_src_b;
            ALU_SUB: alu_s = i_src_a - i_src_b;
            ALU_AND: alu_s = i_src_a & i_src_b;
            ALU_OR:  alu_s = i_src_a | i_src_b;
            ALU_SLT: alu_s = {{(XLEN-1){1'b0}}, ($signed(i_src_a) < $signed(i_src_b))};
            default: alu_s = i_src_a;
        endcase
    end

    // Handshake FSM next-state and next output values
    always_comb begin
        state_next_s  = state_r;
        load_s        = 1'b0;
        valid_next_s  = o_valid;
        busy_next_s   = 1'b0;
        result_next_s = o_result;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    if (is_shift_op(i_alu_ctrl) && (shamt_s != {SHAMT_W{1'b0}})) begin
                        load_s       = 1'b1;
                        state_next_s = SHIFT;
                        valid_next_s = 1'b0;
                        busy_next_s  = 1'b1;
                    end else begin
                        result_next_s = alu_s;
                        state_next_s  = DONE;
                        valid_next_s  = 1'b1;
                    end
                end else if ((state_r == DONE) && !i_ready) begin
                    state_next_s = DONE;
                    valid_next_s = 1'b1;
                end else begin
                    state_next_s = IDLE;
                    valid_next_s = 1'b0;
                end
            end
            SHIFT: begin
                if (shift_done_s) begin
                    result_next_s = shift_step_s;
                    state_next_s  = DONE;
                    valid_next_s  = 1'b1;
                end else begin
                    busy_next_s = 1'b1;
                end
            end
            default: begin
                state_next_s = IDLE;
                valid_next_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs; zero flag travels with the result
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r  <= IDLE;
            o_valid  <= 1'b0;
            o_result <= {XLEN{1'b0}};
            o_zero   <= 1'b1;
            o_busy   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            o_valid  <= valid_next_s;
            o_result <= result_next_s;
            o_zero   <= (result_next_s == {XLEN{1'b0}});
            o_busy   <= busy_next_s;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a transaction-level model.
module tb_alu_exec_unit;

    localparam logic [2:0] C_ADD = 3'b000;
    localparam logic [2:0] C_SUB = 3'b001;
    localparam logic [2:0] C_OR  = 3'b011;
    localparam logic [2:0] C_SLL = 3'b100;
    localparam logic [2:0] C_SLT = 3'b101;
    localparam logic [2:0] C_SRL = 3'b110;
    localparam logic [2:0] C_SRA = 3'b111;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_alu_ctrl;
    logic [31:0] i_src_a;
    logic [31:0] i_src_b;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_zero;
    logic        o_busy;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_alu_ctrl (i_alu_ctrl),
        .i_src_a    (i_src_a),
        .i_src_b    (i_src_b),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result),
        .o_zero     (o_zero),
        .o_busy     (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of an operation, from the opcode definitions
    function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        int sh;
        logic [31:0] r;
        sh = int'(b[4:0]);
        case (c)
            C_ADD:   r = a + b;
            C_SUB:   r = a - b;
            3'b010:  r = a & b;
            C_OR:    r = a | b;
            C_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            C_SLL:   r = a << sh;
            C_SRL:   r = a >> sh;
            default: r = $signed(a) >>> sh;
        endcase
        return r;
    endfunction

    // Transaction model: a result becomes visible after a number of edges set by the op
    logic        m_valid;
    logic        m_busy;
    logic [31:0] m_result;
    logic [31:0] m_pend;
    int          m_cnt;
    logic        m_ready;

    assign m_ready = !m_busy && (!m_valid || i_ready);

    always @(posedge i_clk) begin
        if (i_rst) begin
            m_valid  <= 1'b0;
            m_busy   <= 1'b0;
            m_result <= 32'd0;
            m_cnt    <= 0;
        end else if (m_busy) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_busy   <= 1'b0;
                m_valid  <= 1'b1;
                m_result <= m_pend;
            end
        end else if (i_valid && m_ready) begin
            if (i_alu_ctrl[2] && (i_alu_ctrl != C_SLT) && (i_src_b[4:0] != 5'd0)) begin
                m_busy  <= 1'b1;
                m_valid <= 1'b0;
                m_cnt   <= int'(i_src_b[4:0]);
                m_pend  <= ref_alu(i_alu_ctrl, i_src_a, i_src_b);
            end else begin
                m_valid  <= 1'b1;
                m_result <= ref_alu(i_alu_ctrl, i_src_a, i_src_b);
            end
        end else if (m_valid && i_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge i_clk) begin
        if (chk_en) begin
            chk("valid",  32'(o_valid), 32'(m_valid));
            chk("busy",   32'(o_busy),  32'(m_busy));
            chk("ready",  32'(o_ready), 32'(m_ready));
            chk("result", o_result, m_result);
            chk("zero",   32'(o_zero), (m_result == 32'd0) ? 32'd1 : 32'd0);
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        i_valid    = 1'b1;
        i_alu_ctrl = c;
        i_src_a    = a;
        i_src_b    = b;
    endtask

    // Edges after the accept edge until o_valid, bounded
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!o_valid && lat < 64) begin
            tick();
            lat++;
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int lat;
        i_rst = 1'b1; i_valid = 1'b0; i_alu_ctrl = 3'b000;
        i_src_a = 32'd0; i_src_b = 32'd0; i_ready = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_valid",  32'(o_valid), 32'd0);
        chk("rst_result", o_result, 32'd0);
        chk("rst_zero",   32'(o_zero), 32'd1);
        chk("rst_busy",   32'(o_busy), 32'd0);
        chk("rst_ready",  32'(o_ready), 32'd1);
        i_rst = 1'b0;

        op(C_ADD, 32'h7FFF_FFFF, 32'd1);
        tick();
        chk("add_valid",  32'(o_valid), 32'd1);
        chk("add_result", o_result, 32'h8000_0000);
        chk("add_zero",   32'(o_zero), 32'd0);

        op(C_SUB, 32'd5, 32'd5);
        tick();
        chk("sub_result", o_result, 32'd0);
        chk("sub_zero",   32'(o_zero), 32'd1);
        chk("sub_ready",  32'(o_ready), 32'd1);
        op(C_SLT, 32'hFFFF_FFFF, 32'd1);
        tick();
        chk("slt_valid",  32'(o_valid), 32'd1);
        chk("slt_result", o_result, 32'd1);
        i_valid = 1'b0;

        op(C_SRA, 32'h8000_0000, 32'hFFFF_FFE4);
        tick();
        i_valid = 1'b0;
        chk("sra_busy",  32'(o_busy), 32'd1);
        chk("sra_ready", 32'(o_ready), 32'd0);
        wait_valid(lat);
        chk("sra_latency", 32'(lat), 32'd4);
        chk("sra_result",  o_result, 32'hF800_0000);
        tick();

        op(C_SRL, 32'h8000_0000, 32'd31);
        tick();
        i_valid = 1'b0;
        wait_valid(lat);
        chk("srl_latency", 32'(lat), 32'd31);
        chk("srl_result",  o_result, 32'h0000_0001);
        tick();

        op(C_SLL, 32'h0000_1234, 32'hFFFF_FFE0);
        tick();
        i_valid = 1'b0;
        chk("sll0_valid",  32'(o_valid), 32'd1);
        chk("sll0_busy",   32'(o_busy), 32'd0);
        chk("sll0_result", o_result, 32'h0000_1234);
        tick();

        i_ready = 1'b0;
        op(C_OR, 32'h0000_00F0, 32'h0000_000F);
        tick();
        op(C_ADD, 32'd1, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid",  32'(o_valid), 32'd1);
            chk("stall_result", o_result, 32'h0000_00FF);
            chk("stall_zero",   32'(o_zero), 32'd0);
            chk("stall_ready",  32'(o_ready), 32'd0);
            tick();
        end
        i_ready = 1'b1;
        #1;
        chk("stall_release_ready", 32'(o_ready), 32'd1);
        tick();
        chk("stall_next_result", o_result, 32'd2);
        i_valid = 1'b0;
        tick();

        op(C_SLL, 32'd1, 32'd10);
        tick();
        i_valid = 1'b0;
        tick();
        i_rst = 1'b1;
        tick();
        chk("midrst_valid",  32'(o_valid), 32'd0);
        chk("midrst_busy",   32'(o_busy), 32'd0);
        chk("midrst_result", o_result, 32'd0);
        i_rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("midrst_no_stale", 32'(o_valid), 32'd0);
        end

        for (int i = 0; i < 400; i++) begin
            i_valid    = ($urandom_range(0, 1) == 1);
            i_alu_ctrl = 3'($urandom_range(0, 7));
            i_src_a    = pick_operand();
            i_src_b    = ($urandom_range(0, 7) == 0) ? i_src_a : pick_operand();
            i_ready    = ($urandom_range(0, 3) != 0);
            i_rst      = ($urandom_range(0, 99) == 0);
            tick();
        end
        i_rst = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (40) tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
